neuron_cfg_loader: RTL and testbench

- Streaming configuration master for the FNN accelerator.
- Accepts a packed 32-bit word stream (valid/ready) from the host DMA and drives the shared neuron configuration bus: config_layer_num, config_neuron_num, weightValid/weightValue, biasValid/biasValue.
- It is the transmitter side of the per-neuron weight-load interface. Every neuron snoops this bus and latches words when weightValid and its layer/neuron IDs match.

---
 rtl/neuron_cfg_loader_pkg.sv | 11 +
 rtl/neuron_cfg_loader_if.sv | 16 +
 rtl/neuron_cfg_loader_hdr_decode.sv | 21 ++
 rtl/neuron_cfg_loader.sv | 87 ++++++++
 tb/tb_neuron_cfg_loader.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/neuron_cfg_loader_pkg.sv
// fnn_cfg_pkg: shared loader state type and header field layout
package fnn_cfg_pkg;
  typedef enum logic [2:0] {IDLE, WEIGHTS, BIAS, DRAIN, DONE} cfg_state_t;
  localparam int LAYER_MSB = 31;
  localparam int LAYER_LSB = 24;
  localparam int NEURON_MSB = 23;
  localparam int NEURON_LSB = 16;
  localparam int COUNT_MSB = 15;
  localparam int COUNT_LSB = 0;
  localparam logic [7:0] END_LAYER = 8'hFF;
endpackage

// File: rtl/neuron_cfg_loader_if.sv
// neuron_cfg_if: host word stream in, neuron configuration bus out
interface neuron_cfg_if;
  logic [31:0] s_data;
  logic s_valid;
  logic s_ready;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic weightValid;
  logic [31:0] weightValue;
  logic biasValid;
  logic [31:0] biasValue;
  modport master(input s_data, s_valid, output s_ready, config_layer_num, config_neuron_num,
                 weightValid, weightValue, biasValid, biasValue);
  modport slave(output s_data, s_valid, input s_ready, config_layer_num, config_neuron_num,
                weightValid, weightValue, biasValid, biasValue);
endinterface

// File: rtl/neuron_cfg_loader_hdr_decode.sv
// cfg_hdr_decode: splits a frame header and classifies it as end marker or malformed
module cfg_hdr_decode import fnn_cfg_pkg::*; #(
  parameter int MAX_WEIGHTS = 784,
  parameter int CNT_W = 16
) (
  input  logic [31:0] hdr,
  output logic [7:0] layer,
  output logic [7:0] neuron,
  output logic [CNT_W-1:0] count,
  output logic is_end,
  output logic is_bad
);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WEIGHTS);
  always_comb begin
    layer = hdr[LAYER_MSB:LAYER_LSB];
    neuron = hdr[NEURON_MSB:NEURON_LSB];
    count = CNT_W'(hdr[COUNT_MSB:COUNT_LSB]);
    is_end = layer == END_LAYER && count == '0;
    is_bad = !is_end && (count == '0 || count > MAX_W);
  end
endmodule

// File: rtl/neuron_cfg_loader.sv
// neuron_cfg_loader: turns a header/weight/bias word stream into neuron config bus pulses
module neuron_cfg_loader import fnn_cfg_pkg::*; #(
  parameter int MAX_WEIGHTS = 784,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  neuron_cfg_if.master bus,
  output logic cfg_busy,
  output logic cfg_done,
  output logic cfg_err
);
  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
  cfg_state_t state;
  logic [CNT_W:0] cnt;
  logic [7:0] layer, neuron;
  logic [CNT_W-1:0] count;
  logic is_end, is_bad, xfer, last;
  cfg_hdr_decode #(.MAX_WEIGHTS(MAX_WEIGHTS), .CNT_W(CNT_W)) u_dec (
    .hdr(bus.s_data), .layer(layer), .neuron(neuron), .count(count),
    .is_end(is_end), .is_bad(is_bad)
  );
  always_comb begin
    bus.s_ready = !rst && state != DONE;
    xfer = bus.s_valid && bus.s_ready;
    last = cnt == ONE;
    cfg_busy = state == WEIGHTS || state == BIAS || state == DRAIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      bus.config_layer_num <= '0;
      bus.config_neuron_num <= '0;
      bus.weightValid <= 1'b0;
      bus.weightValue <= '0;
      bus.biasValid <= 1'b0;
      bus.biasValue <= '0;
    end else begin
      bus.weightValid <= 1'b0;
      bus.biasValid <= 1'b0;
      if (xfer) begin
        unique case (state)
          IDLE: begin
            if (is_end) begin
              state <= DONE;
              cfg_done <= 1'b1;
            end else if (is_bad) begin
              state <= DRAIN;
              cfg_err <= 1'b1;
              cnt <= {1'b0, count} + ONE;
            end else begin
              state <= WEIGHTS;
              cnt <= {1'b0, count};
              bus.config_layer_num <= {24'b0, layer};
              bus.config_neuron_num <= {24'b0, neuron};
            end
          end
          WEIGHTS: begin
            bus.weightValid <= 1'b1;
            bus.weightValue <= bus.s_data;
            cnt <= cnt - ONE;
            state <= last ? BIAS : WEIGHTS;
          end
          BIAS: begin
            bus.biasValid <= 1'b1;
            bus.biasValue <= bus.s_data;
            state <= IDLE;
          end
          DRAIN: begin
            cnt <= cnt - ONE;
            state <= last ? IDLE : DRAIN;
          end
          default: state <= state;
        endcase
      end
      if (state == DONE && restart) begin
        state <= IDLE;
        cfg_done <= 1'b0;
        cfg_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_neuron_cfg_loader.sv
// tb_neuron_cfg_loader: directed frames checked against hand-computed bus activity
module tb_neuron_cfg_loader;
  logic clk = 1'b0;
  logic rst, restart, cfg_busy, cfg_done, cfg_err;
  int checks = 0, errors = 0, cyc = 0, spur = 0, both = 0;
  logic xq = 1'b0;
  logic [31:0] wq[$], wn[$], bq[$], bn[$];
  int wc[$];
  neuron_cfg_if bus();
  neuron_cfg_loader dut (.clk(clk), .rst(rst), .restart(restart), .bus(bus),
                         .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    xq <= !rst && bus.s_valid && bus.s_ready;
  end
  always @(negedge clk) if (!rst) begin
    if ((bus.weightValid || bus.biasValid) && !xq) spur++;
    if (bus.weightValid && bus.biasValid) both++;
    if (bus.weightValid) begin
      wq.push_back(bus.weightValue);
      wn.push_back(bus.config_neuron_num);
      wc.push_back(cyc);
    end
    if (bus.biasValid) begin
      bq.push_back(bus.biasValue);
      bn.push_back(bus.config_neuron_num);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [31:0] w, input int gap = 0);
    repeat (gap) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data = w;
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask
  task automatic flush();
    repeat (2) @(negedge clk);
    wq.delete(); wn.delete(); wc.delete(); bq.delete(); bn.delete();
    spur = 0;
    both = 0;
  endtask
  initial begin
    int g[8] = '{0, 2, 1, 0, 3, 0, 1, 2};
    logic [31:0] f[8] = '{32'h01000002, 32'hA1, 32'hA2, 32'hB1, 32'h01010002, 32'hA3, 32'hA4, 32'hB2};
    rst = 1'b1;
    restart = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.s_ready, 0);
    chk("rst_wv", bus.weightValid, 0);
    chk("rst_layer", bus.config_layer_num, 0);
    chk("rst_flags", {cfg_busy, cfg_done, cfg_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", bus.s_ready, 1);
    send(32'h02040003); send(32'h11); send(32'h22); send(32'h33); send(32'h07C2);
    repeat (2) @(negedge clk);
    chk("t1_nw", wq.size(), 3);
    chk("t1_w0", wq[0], 32'h11);
    chk("t1_w1", wq[1], 32'h22);
    chk("t1_w2", wq[2], 32'h33);
    chk("t1_consec", wc[2] - wc[0], 2);
    chk("t1_nb", bq.size(), 1);
    chk("t1_bias", bq[0], 32'h07C2);
    chk("t1_layer", bus.config_layer_num, 2);
    chk("t1_neuron", bus.config_neuron_num, 4);
    chk("t1_err", cfg_err, 0);
    flush();
    for (int i = 0; i < 8; i++) send(f[i], g[i]);
    repeat (2) @(negedge clk);
    chk("t2_nw", wq.size(), 4);
    chk("t2_nb", bq.size(), 2);
    chk("t2_wn1", wn[1], 0);
    chk("t2_wn2", wn[2], 1);
    chk("t2_bn0", bn[0], 0);
    chk("t2_bn1", bn[1], 1);
    chk("t2_w3", wq[3], 32'hA4);
    chk("t2_b1", bq[1], 32'hB2);
    chk("t2_spur", spur, 0);
    chk("t2_both", both, 0);
    flush();
    send(32'h04060310);
    for (int i = 0; i < 784; i++) send(32'h10000000 + i);
    send(32'hB4);
    repeat (2) @(negedge clk);
    chk("t4_nw", wq.size(), 784);
    chk("t4_w0", wq[0], 32'h10000000);
    chk("t4_wlast", wq[783], 32'h1000030F);
    chk("t4_nb", bq.size(), 1);
    chk("t4_bias", bq[0], 32'hB4);
    chk("t4_err", cfg_err, 0);
    chk("t4_ids", {bus.config_layer_num[7:0], bus.config_neuron_num[7:0]}, 32'h0406);
    flush();
    send(32'h03000311);
    chk("t3_err", cfg_err, 1);
    chk("t3_busy", cfg_busy, 1);
    for (int i = 0; i < 786; i++) send(32'hC0000000 + i);
    chk("t3_idle", cfg_busy, 0);
    send(32'h03050001); send(32'hAA); send(32'hBB);
    repeat (2) @(negedge clk);
    chk("t3_nw", wq.size(), 1);
    chk("t3_w0", wq[0], 32'hAA);
    chk("t3_nb", bq.size(), 1);
    chk("t3_bias", bq[0], 32'hBB);
    chk("t3_ids", {bus.config_layer_num[7:0], bus.config_neuron_num[7:0]}, 32'h0305);
    chk("t3_err_sticky", cfg_err, 1);
    flush();
    send(32'hFF000000);
    chk("t5_done", cfg_done, 1);
    chk("t5_ready", bus.s_ready, 0);
    chk("t5_busy", cfg_busy, 0);
    bus.s_valid = 1'b1;
    bus.s_data = 32'h01020001;
    repeat (3) @(negedge clk);
    bus.s_valid = 1'b0;
    chk("t5_done_hold", cfg_done, 1);
    chk("t5_ignored", bus.config_neuron_num, 5);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("t5_ready_after", bus.s_ready, 1);
    chk("t5_flags_clr", {cfg_done, cfg_err}, 0);
    chk("t5_nw", wq.size(), 0);
    flush();
    send(32'h05070005); send(32'h1); send(32'h2);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ready", bus.s_ready, 0);
    chk("t6_wv", bus.weightValid, 0);
    chk("t6_wval", bus.weightValue, 0);
    chk("t6_layer", bus.config_layer_num, 0);
    chk("t6_busy", cfg_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    flush();
    send(32'h06080001); send(32'h5A); send(32'hA5);
    repeat (2) @(negedge clk);
    chk("t6_ids", {bus.config_layer_num[7:0], bus.config_neuron_num[7:0]}, 32'h0608);
    chk("t6_nw", wq.size(), 1);
    chk("t6_w0", wq[0], 32'h5A);
    chk("t6_bias", bq[0], 32'hA5);
    chk("t6_busy_end", cfg_busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
